// File: rtl/piso_frame_tx.sv
// piso_frame_tx
// Parallel-in/serial-out frame transmitter for the NVM read path. A DATA_W-bit
// word is taken on a VALID/READY handshake and sent as a UART-style frame:
// start bit (0), data bits (LSB first, or MSB first when MSB_FIRST=1),
// optional even parity bit, then STOP_BITS stop bits (1). Each serial bit is
// held for BIT_CYCLES clocks, and the line idles high.
//
// Build option: define PISO_PARITY_EN to insert one even-parity bit after the
// data bits. The parity bit is the XOR of the captured D_In. When the macro is
// undefined, no parity logic is built.
//
// Ports
//   CLK    in   clock, all logic on posedge
//   RST    in   synchronous reset, active low, has priority over EN
//   EN     in   transmit enable; low aborts any frame and forces idle
//   D_In   in   parallel data word (DATA_W bits), sampled on the handshake edge
//   VALID  in   D_In valid
//   READY  out  word can be accepted this cycle (combinational)
//   D_Out  out  serial line, idle high
//   BUSY   out  frame in progress (registered)
//   DONE   out  one-cycle pulse during the final clock of the last stop bit
module piso_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [DATA_W-1:0] D_In,
  input  logic              VALID,
  output logic              READY,
  output logic              D_Out,
  output logic              BUSY,
  output logic              DONE
);

`ifdef PISO_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int FRAME_W = 1 + DATA_W + PAR_W + STOP_BITS;
  localparam int BAUD_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [FRAME_W-1:0]   shreg_reg, shreg_next;
  logic [BAUD_W-1:0]    baud_reg, baud_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic                 busy_reg, busy_next;

  logic [DATA_W-1:0]    data_ord;
  logic [FRAME_W-1:0]   frame_load;
  logic                 baud_wrap;
  logic                 last_tick;

  // Data bit order. The shift register always sends bit 0 first, so MSB-first
  // mode reverses the word before loading.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_order
      if (MSB_FIRST != 0) begin : g_msb
        assign data_ord[gi] = D_In[DATA_W-1-gi];
      end else begin : g_lsb
        assign data_ord[gi] = D_In[gi];
      end
    end
  endgenerate

`ifdef PISO_PARITY_EN
  logic parity;
  // Even parity over the word as captured (independent of send order).
  assign parity     = ^D_In;
  assign frame_load = {{STOP_BITS{1'b1}}, parity, data_ord, 1'b0};
`else
  assign frame_load = {{STOP_BITS{1'b1}}, data_ord, 1'b0};
`endif

  assign baud_wrap = (baud_reg == BAUD_LAST);
  // Final clock of the final stop bit: the frame ends at the next edge, so a
  // new word may be accepted on that same edge (no idle gap).
  assign last_tick = (state_reg == SHIFT) && baud_wrap && (bit_reg == BIT_LAST);

  assign READY = EN && ((state_reg == IDLE) || last_tick);
  assign DONE  = EN && last_tick;
  assign D_Out = (state_reg == SHIFT) ? shreg_reg[0] : 1'b1;
  assign BUSY  = busy_reg;

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    busy_next  = busy_reg;

    if (!EN) begin
      // Abort: the partial frame is dropped, not resumed.
      state_next = IDLE;
      shreg_next = '1;
      baud_next  = '0;
      bit_next   = '0;
      busy_next  = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (VALID) begin
            state_next = SHIFT;
            shreg_next = frame_load;
            baud_next  = '0;
            bit_next   = '0;
            busy_next  = 1'b1;
          end
        end
        SHIFT: begin
          if (!baud_wrap) begin
            baud_next = baud_reg + 1'b1;
          end else begin
            baud_next = '0;
            if (bit_reg == BIT_LAST) begin
              bit_next = '0;
              if (VALID) begin
                // Back-to-back frame: reload straight from the last stop bit.
                shreg_next = frame_load;
                busy_next  = 1'b1;
              end else begin
                state_next = IDLE;
                shreg_next = '1;
                busy_next  = 1'b0;
              end
            end else begin
              shreg_next = {1'b1, shreg_reg[FRAME_W-1:1]};
              bit_next   = bit_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= IDLE;
      shreg_reg <= '1;
      baud_reg  <= '0;
      bit_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      busy_reg  <= busy_next;
    end
  end

endmodule
